// File: rtl/key_load_sequencer.sv
// Key-to-load-word sequencer: accepts one full key, emits it LOAD_W bits at a time (low slice first),
// plus an independent seedable Fibonacci LFSR pattern source.
module key_load_sequencer #(
    parameter int unsigned KEY_W     = 128,
    parameter int unsigned LOAD_W    = 64,
    parameter int unsigned LFSR_W    = 20,
    parameter logic [LFSR_W-1:0] LFSR_INIT = LFSR_W'(20'h99999),
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(20'h90000),
    localparam int unsigned N        = KEY_W / LOAD_W,
    localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [KEY_W-1:0]  key,
    output logic              load_valid,
    input  logic              load_ready,
    output logic [LOAD_W-1:0] load,
    output logic [IDX_W-1:0]  load_idx,
    output logic              load_last,
    input  logic              lfsr_en,
    input  logic              lfsr_seed_we,
    input  logic [LFSR_W-1:0] lfsr_seed,
    output logic [LFSR_W-1:0] lfsr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]   idx_q, idx_d, nxt_idx;
    logic [LOAD_W-1:0]  load_q, load_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;

    // Key FSM state and registered load-port outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            load_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            load_q   <= load_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    // Next-state and next-output decode; every output is precomputed one edge ahead
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        load_d   = load_q;
        valid_d  = valid_q;
        last_d   = last_q;
        nxt_idx  = idx_q + IDX_W'(1);
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    shadow_d = key;
                    idx_d    = '0;
                    load_d   = key[LOAD_W-1:0];
                    valid_d  = 1'b1;
                    last_d   = (N == 1);
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (load_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        load_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = nxt_idx;
                        load_d = LOAD_W'(shadow_q >> (LOAD_W * 32'(nxt_idx)));
                        last_d = (nxt_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // LFSR: seed beats step beats hold; an all-zero seed would lock up, so it maps to LFSR_INIT
    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_seed_we) begin
            lfsr_d = (lfsr_seed == '0) ? LFSR_INIT : lfsr_seed;
        end else if (lfsr_en) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_INIT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign key_ready  = (state_q == IDLE);
    assign load_valid = valid_q;
    assign load       = load_q;
    assign load_idx   = idx_q;
    assign load_last  = last_q;
    assign lfsr       = lfsr_q;

endmodule

// File: tb/tb_key_load_sequencer.sv
// Directed bench for key_load_sequencer: default 128/64 instance plus a single-slice 32/32 instance.
module tb_key_load_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic         key_valid, key_ready, load_valid, load_ready, load_last;
    logic [127:0] key;
    logic [63:0]  load;
    logic [0:0]   load_idx;
    logic         lfsr_en, lfsr_seed_we;
    logic [19:0]  lfsr_seed, lfsr;

    // Single-slice instance
    logic         key_valid1, key_ready1, load_valid1, load_ready1, load_last1;
    logic [31:0]  key1, load1;
    logic [0:0]   load_idx1;
    logic [19:0]  lfsr1;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] K1 = 128'h0123456789ABCDEF_FEDCBA9876543210;

    key_load_sequencer u0 (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_ready(key_ready), .key(key),
        .load_valid(load_valid), .load_ready(load_ready), .load(load),
        .load_idx(load_idx), .load_last(load_last),
        .lfsr_en(lfsr_en), .lfsr_seed_we(lfsr_seed_we), .lfsr_seed(lfsr_seed), .lfsr(lfsr)
    );

    key_load_sequencer #(.KEY_W(32), .LOAD_W(32)) u1 (
        .clk(clk), .rst(rst),
        .key_valid(key_valid1), .key_ready(key_ready1), .key(key1),
        .load_valid(load_valid1), .load_ready(load_ready1), .load(load1),
        .load_idx(load_idx1), .load_last(load_last1),
        .lfsr_en(1'b0), .lfsr_seed_we(1'b0), .lfsr_seed(20'h0), .lfsr(lfsr1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] w,
                           input logic i, input logic l, input logic kr);
        chk({tag, ".valid"}, 128'(load_valid), 128'(v));
        chk({tag, ".load"},  128'(load),       128'(w));
        chk({tag, ".idx"},   128'(load_idx),   128'(i));
        chk({tag, ".last"},  128'(load_last),  128'(l));
        chk({tag, ".kready"},128'(key_ready),  128'(kr));
    endtask

    initial begin
        rst = 1'b0;
        key_valid = 1'b0; key = '0; load_ready = 1'b0;
        lfsr_en = 1'b0; lfsr_seed_we = 1'b0; lfsr_seed = '0;
        key_valid1 = 1'b0; key1 = '0; load_ready1 = 1'b0;
        #23;
        chk_out("reset", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("reset.lfsr", 128'(lfsr), 128'(20'h99999));
        @(negedge clk);
        rst = 1'b1;

        // Two-slice delivery with load_ready held high
        key_valid = 1'b1; key = K1; load_ready = 1'b1;
        tick();
        key_valid = 1'b0;
        chk_out("k1.s0", 1'b1, 64'hFEDCBA9876543210, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("k1.s1", 1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("k1.done", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);

        // Backpressure on slice 0 while a second key is offered and must be ignored
        load_ready = 1'b0; key_valid = 1'b1; key = K1;
        tick();
        key = 128'h1;
        for (int c = 0; c < 5; c++) begin
            chk_out($sformatf("bp.hold%0d", c), 1'b1, 64'hFEDCBA9876543210, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk_out("bp.hold5", 1'b1, 64'hFEDCBA9876543210, 1'b0, 1'b0, 1'b0);
        load_ready = 1'b1;
        tick();
        chk_out("bp.s1", 1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("bp.idle", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        tick();
        key_valid = 1'b0;
        chk_out("k2.s0", 1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("k2.s1", 1'b1, 64'h0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("k2.done", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-SEND after slice 0 is accepted
        key_valid = 1'b1; key = K1;
        tick();
        key_valid = 1'b0;
        tick();
        chk_out("rs.s1", 1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_out("rs.async", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_out("rs.after", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);

        // LFSR stepping, zero-seed substitution and seed priority over step
        chk("lfsr.init", 128'(lfsr), 128'(20'h99999));
        lfsr_en = 1'b1;
        tick();
        chk("lfsr.step1", 128'(lfsr), 128'(20'h33332));
        tick();
        chk("lfsr.step2", 128'(lfsr), 128'(20'h66665));
        lfsr_seed_we = 1'b1; lfsr_seed = 20'h0;
        tick();
        chk("lfsr.seed0", 128'(lfsr), 128'(20'h99999));
        lfsr_seed = 20'h12345;
        tick();
        chk("lfsr.seed", 128'(lfsr), 128'(20'h12345));
        lfsr_seed_we = 1'b0; lfsr_en = 1'b0;
        tick();
        chk("lfsr.hold", 128'(lfsr), 128'(20'h12345));

        // Single-slice configuration: one word per key, two-cycle turnaround
        key_valid1 = 1'b1; key1 = 32'hDEADBEEF; load_ready1 = 1'b1;
        tick();
        key1 = 32'hCAFEF00D;
        chk("n1.a.valid", 128'(load_valid1), 128'(1'b1));
        chk("n1.a.load",  128'(load1),       128'(32'hDEADBEEF));
        chk("n1.a.idx",   128'(load_idx1),   128'(1'b0));
        chk("n1.a.last",  128'(load_last1),  128'(1'b1));
        chk("n1.a.kready",128'(key_ready1),  128'(1'b0));
        tick();
        chk("n1.gap.valid", 128'(load_valid1), 128'(1'b0));
        chk("n1.gap.kready",128'(key_ready1),  128'(1'b1));
        tick();
        key_valid1 = 1'b0;
        chk("n1.b.load",  128'(load1),      128'(32'hCAFEF00D));
        chk("n1.b.last",  128'(load_last1), 128'(1'b1));
        chk("n1.b.idx",   128'(load_idx1),  128'(1'b0));
        tick();
        chk("n1.done.valid", 128'(load_valid1), 128'(1'b0));
        chk("n1.done.load",  128'(load1),       128'(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
